// File: rtl/life_run_ctrl.sv
// Run controller for the 8x8 Life grid datapath: seeds the grid, paces generation steps,
// handles pause/single-step and stops on extinction, still life or a generation limit.
module life_run_ctrl #(
  parameter int GRID_W = 64,
  parameter int DIV_W  = 8,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  input  logic [GRID_W-1:0] seed,
  input  logic [DIV_W-1:0]  period,
  input  logic [GEN_W-1:0]  max_gen,
  input  logic [GRID_W-1:0] dp_grid,
  output logic              dp_load,
  output logic [GRID_W-1:0] dp_seed,
  output logic              dp_step,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_dp_load;
  logic              r_dp_step;
  logic              r_busy;
  logic              r_done;
  logic [GRID_W-1:0] r_seed;
  logic [GRID_W-1:0] r_prev;
  logic [GEN_W-1:0]  r_gen;
  logic [1:0]        r_status;
  logic [DIV_W-1:0]  r_tick;

  logic [DIV_W-1:0]  w_last_tick;
  logic [DIV_W-1:0]  w_tick_inc;
  logic [GEN_W-1:0]  w_gen_inc;

  // r_tick counts completed RUN cycles; the step cycle is the one entered with r_tick == P-1.
  assign w_last_tick = (period == '0) ? '0 : period - 1'b1;
  assign w_tick_inc  = r_tick + 1'b1;
  assign w_gen_inc   = (&r_gen) ? r_gen : r_gen + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dp_load <= 1'b0;
      r_dp_step <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_seed    <= '0;
      r_prev    <= '0;
      r_gen     <= '0;
      r_status  <= 2'b00;
      r_tick    <= '0;
    end else begin
      r_dp_load <= 1'b0;
      r_dp_step <= 1'b0;
      if (start) begin
        r_seed    <= seed;
        r_gen     <= '0;
        r_status  <= 2'b00;
        r_tick    <= '0;
        r_state   <= S_LOAD;
        r_dp_load <= 1'b1;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (r_seed == '0) begin
              r_state  <= S_DONE;
              r_status <= 2'b01;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (pause) begin
              r_state <= S_PAUSED;
            end else begin
              r_state   <= S_RUN;
              r_tick    <= '0;
              r_dp_step <= (w_last_tick == '0);
            end
          end
          S_RUN, S_PAUSED: begin
            // A step already on the wire completes before pause or anything else is honoured.
            if (r_dp_step) begin
              r_prev  <= dp_grid;
              r_gen   <= w_gen_inc;
              r_tick  <= '0;
              r_state <= S_CHECK;
            end else if (r_state == S_RUN) begin
              if (pause) begin
                r_state <= S_PAUSED;
              end else begin
                r_tick    <= w_tick_inc;
                r_dp_step <= (w_tick_inc >= w_last_tick);
              end
            end else if (step) begin
              r_dp_step <= 1'b1;
            end else if (!pause) begin
              r_state   <= S_RUN;
              r_dp_step <= (r_tick >= w_last_tick);
            end
          end
          S_CHECK: begin
            if (dp_grid == '0) begin
              r_state  <= S_DONE;
              r_status <= 2'b01;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (dp_grid == r_prev) begin
              r_state  <= S_DONE;
              r_status <= 2'b10;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if ((max_gen != '0) && (r_gen == max_gen)) begin
              r_state  <= S_DONE;
              r_status <= 2'b11;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (pause) begin
              r_state <= S_PAUSED;
            end else begin
              r_state   <= S_RUN;
              r_dp_step <= (w_last_tick == '0);
            end
          end
          S_IDLE, S_DONE: begin
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dp_load   = r_dp_load;
  assign dp_seed   = r_seed;
  assign dp_step   = r_dp_step;
  assign gen_count = r_gen;
  assign busy      = r_busy;
  assign done      = r_done;
  assign status    = r_status;
  assign dbg_state = r_state;

endmodule
